// File: rtl/snitch_muldiv_arbiter.sv
// Round-robin arbiter sharing one MUL/DIV unit among NrCores, with in-order response routing.
// Optional cycle-conflict counter is built only when SNITCH_MULDIV_ARB_PERF_EN is defined.
module snitch_muldiv_arbiter #(
    parameter int NrCores        = 8,
    parameter int DataWidth      = 96,
    parameter int RspWidth       = 38,
    parameter int MaxOutstanding = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NrCores*DataWidth-1:0] req_data_i,
    input  logic [NrCores-1:0]           req_valid_i,
    output logic [NrCores-1:0]           req_ready_o,
    output logic [DataWidth-1:0]         acc_q_data_o,
    output logic                         acc_q_valid_o,
    input  logic                         acc_q_ready_i,
    input  logic [RspWidth-1:0]          acc_p_data_i,
    input  logic                         acc_p_valid_i,
    output logic                         acc_p_ready_o,
    output logic [RspWidth-1:0]          rsp_data_o,
    output logic [NrCores-1:0]           rsp_valid_o,
    input  logic [NrCores-1:0]           rsp_ready_i,
    output logic [31:0]                  conflict_cnt_o
);

    localparam int IdxW = (NrCores > 1) ? $clog2(NrCores) : 1;
    localparam int PtrW = $clog2(MaxOutstanding);

    logic [DataWidth-1:0] req_data_arr [NrCores];

    logic [IdxW-1:0] rr_ptr_reg;
    logic [IdxW-1:0] rr_ptr_next;
    logic            lock_reg;
    logic [IdxW-1:0] lock_idx_reg;
    logic [IdxW-1:0] rr_pick;
    logic            rr_found;
    logic [IdxW-1:0] grant_idx;
    logic            grant_valid;
    logic            q_hs;
    logic            p_hs;

    logic [IdxW-1:0] fifo_mem [MaxOutstanding];
    logic [PtrW:0]   wr_ptr_reg;
    logic [PtrW:0]   rd_ptr_reg;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IdxW-1:0] head_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NrCores; gi++) begin : g_unpack
            assign req_data_arr[gi] = req_data_i[gi*DataWidth +: DataWidth];
        end
    endgenerate

    // Walk offsets from the far end so the closest valid core to rr_ptr wins.
    always_comb begin
        int cand;
        cand     = 0;
        rr_pick  = '0;
        rr_found = 1'b0;
        for (int off = NrCores - 1; off >= 0; off--) begin
            cand = int'(rr_ptr_reg) + off;
            if (cand >= NrCores) begin
                cand = cand - NrCores;
            end
            if (req_valid_i[cand[IdxW-1:0]]) begin
                rr_pick  = cand[IdxW-1:0];
                rr_found = 1'b1;
            end
        end
    end

    // A stalled offer keeps its core until the unit accepts it.
    assign grant_idx   = lock_reg ? lock_idx_reg : rr_pick;
    assign grant_valid = lock_reg ? req_valid_i[lock_idx_reg] : rr_found;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PtrW] != rd_ptr_reg[PtrW]) &&
                        (wr_ptr_reg[PtrW-1:0] == rd_ptr_reg[PtrW-1:0]);
    assign head_idx   = fifo_mem[rd_ptr_reg[PtrW-1:0]];

    assign acc_q_valid_o = rst_ni & grant_valid & ~fifo_full;
    assign acc_q_data_o  = req_data_arr[grant_idx];
    assign q_hs          = acc_q_valid_o & acc_q_ready_i;

    assign acc_p_ready_o = ~fifo_empty & rsp_ready_i[head_idx];
    assign rsp_data_o    = acc_p_data_i;
    assign p_hs          = acc_p_valid_i & acc_p_ready_o;

    generate
        for (gi = 0; gi < NrCores; gi++) begin : g_per_core
            assign req_ready_o[gi] = q_hs & (grant_idx == IdxW'(gi));
            assign rsp_valid_o[gi] = ~fifo_empty & acc_p_valid_i & (head_idx == IdxW'(gi));
        end
    endgenerate

    assign rr_ptr_next = (grant_idx == IdxW'(NrCores - 1)) ? '0 : grant_idx + IdxW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_reg   <= '0;
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            lock_reg     <= acc_q_valid_o & ~acc_q_ready_i;
            lock_idx_reg <= grant_idx;
            if (q_hs) begin
                rr_ptr_reg <= rr_ptr_next;
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (p_hs) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (q_hs) begin
            fifo_mem[wr_ptr_reg[PtrW-1:0]] <= grant_idx;
        end
    end

`ifdef SNITCH_MULDIV_ARB_PERF_EN
    logic [31:0] conflict_cnt_reg;
    logic        multi_valid;

    // With two or more requesters at least one of them is left waiting this cycle.
    assign multi_valid = ($countones(req_valid_i) >= 2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_reg <= '0;
        end else if (multi_valid && (conflict_cnt_reg != '1)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_reg;
`else
    assign conflict_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    rsp_on_empty_fifo: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(acc_p_valid_i && fifo_empty))
        else $error("response arrived with no outstanding request");
`endif

endmodule
